// File: rtl/param_lock_if.sv
// Handshake bundle for the combination lock: digit entry and control
// strobes towards the lock, state and counters back from it.
interface param_lock_if #(
   parameter int DIGIT_W = 4
);
   logic [DIGIT_W-1:0] digit_in;
   logic               digit_vld;
   logic               clear;
   logic               relock;
   logic               prog;
   logic [2:0]         status;
   logic [3:0]         digit_idx;
   logic [3:0]         fail_cnt;
   logic               bad_digit;

   modport master (
      output digit_in, digit_vld, clear, relock, prog,
      input  status, digit_idx, fail_cnt, bad_digit
   );

   modport slave (
      input  digit_in, digit_vld, clear, relock, prog,
      output status, digit_idx, fail_cnt, bad_digit
   );
endinterface

// File: rtl/param_lock.sv
// Programmable digit combination lock with failed-attempt lockout and an
// in-field code programming mode reachable only from OPEN.
module param_lock #(
   parameter int                            N_DIGITS    = 6,
   parameter int                            DIGIT_W     = 4,
   parameter logic [N_DIGITS*DIGIT_W-1:0]   CODE_RST    = 24'h722297,
   parameter int                            MAX_FAILS   = 3,
   parameter int                            LOCK_CYCLES = 16
) (
   input logic        clk,
   input logic        rst_n,
   param_lock_if.slave bus
);
   localparam int CODE_W = N_DIGITS * DIGIT_W;
   localparam int LCW    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
   localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(9);
   localparam logic [3:0]         IDX_LAST  = 4'(N_DIGITS - 1);
   localparam logic [3:0]         FAIL_MAX  = 4'(MAX_FAILS);
   localparam logic [LCW-1:0]     LOCK_LOAD = LCW'(LOCK_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_ENTRY   = 3'd0,
      ST_OPEN    = 3'd1,
      ST_CLOSED  = 3'd2,
      ST_LOCKOUT = 3'd3,
      ST_PROGRAM = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [3:0]         idx_q, idx_d;
   logic [3:0]         fail_q, fail_d;
   logic               mis_q, mis_d;
   logic [LCW-1:0]     lock_q, lock_d;
   logic [CODE_W-1:0]  code_q, code_d;
   logic [CODE_W-1:0]  shadow_q, shadow_d;

   logic [DIGIT_W-1:0] stored_digit_s;
   logic               digit_bad_s;
   logic               digit_miss_s;

   // Digit classification against the stored code (digit 0 sits in the MSBs).
   always_comb begin
      digit_bad_s    = (bus.digit_in > DIGIT_MAX);
      stored_digit_s = code_q[(N_DIGITS - 1 - int'(idx_q)) * DIGIT_W +: DIGIT_W];
      digit_miss_s   = digit_bad_s || (bus.digit_in != stored_digit_s);
   end

   // Next-state and datapath updates for every lock state.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      fail_d   = fail_q;
      mis_d    = mis_q;
      lock_d   = lock_q;
      code_d   = code_q;
      shadow_d = shadow_q;
      case (state_q)
         ST_ENTRY: begin
            if (bus.digit_vld) begin
               if (idx_q == IDX_LAST) begin
                  idx_d = 4'd0;
                  mis_d = 1'b0;
                  if (!(mis_q || digit_miss_s)) begin
                     state_d = ST_OPEN;
                     fail_d  = 4'd0;
                  end else if ((fail_q + 4'd1) == FAIL_MAX) begin
                     state_d = ST_LOCKOUT;
                     fail_d  = fail_q + 4'd1;
                     lock_d  = LOCK_LOAD;
                  end else begin
                     state_d = ST_CLOSED;
                     fail_d  = fail_q + 4'd1;
                  end
               end else begin
                  idx_d = idx_q + 4'd1;
                  mis_d = mis_q || digit_miss_s;
               end
            end else begin
               state_d = ST_ENTRY;
            end
         end
         ST_OPEN: begin
            if (bus.relock) begin
               state_d = ST_ENTRY;
            end else if (bus.prog) begin
               state_d  = ST_PROGRAM;
               idx_d    = 4'd0;
               shadow_d = '0;
            end else begin
               state_d = ST_OPEN;
            end
         end
         ST_CLOSED: begin
            if (bus.clear) begin
               state_d = ST_ENTRY;
            end else begin
               state_d = ST_CLOSED;
            end
         end
         ST_LOCKOUT: begin
            if (lock_q == '0) begin
               state_d = ST_ENTRY;
               fail_d  = 4'd0;
            end else begin
               lock_d = lock_q - LCW'(1);
            end
         end
         ST_PROGRAM: begin
            if (!bus.digit_vld) begin
               state_d = ST_PROGRAM;
            end else if (digit_bad_s) begin
               // Abort: nothing of this pass may reach the stored code.
               state_d  = ST_OPEN;
               idx_d    = 4'd0;
               shadow_d = '0;
            end else if (idx_q == IDX_LAST) begin
               state_d  = ST_ENTRY;
               idx_d    = 4'd0;
               code_d   = {shadow_q[CODE_W-DIGIT_W-1:0], bus.digit_in};
               shadow_d = '0;
            end else begin
               idx_d    = idx_q + 4'd1;
               shadow_d = {shadow_q[CODE_W-DIGIT_W-1:0], bus.digit_in};
            end
         end
         default: begin
            state_d = ST_ENTRY;
            idx_d   = 4'd0;
            mis_d   = 1'b0;
         end
      endcase
   end

   // State, counters and code storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_ENTRY;
         idx_q    <= 4'd0;
         fail_q   <= 4'd0;
         mis_q    <= 1'b0;
         lock_q   <= '0;
         code_q   <= CODE_RST;
         shadow_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         fail_q   <= fail_d;
         mis_q    <= mis_d;
         lock_q   <= lock_d;
         code_q   <= code_d;
         shadow_q <= shadow_d;
      end
   end

   assign bus.status    = state_q;
   assign bus.digit_idx = idx_q;
   assign bus.fail_cnt  = fail_q;
   assign bus.bad_digit = bus.digit_vld & digit_bad_s;
endmodule

// File: doc/param_lock.md
PARAM_LOCK -- requirements
Module: param_lock

Interface
REQ-001 SHALL have parameter N_DIGITS, default 6, number of digits per combination (range 2..16).
REQ-002 SHALL have parameter DIGIT_W, default 4, width of one digit; legal digit values 0..9.
REQ-003 SHALL have parameter CODE_RST, default 24'h722297, reset combination, digit 0 in the most significant DIGIT_W bits, width N_DIGITS*DIGIT_W.
REQ-004 SHALL have parameter MAX_FAILS, default 3, consecutive failed attempts that trigger lockout (range 1..15).
REQ-005 SHALL have parameter LOCK_CYCLES, default 16, lockout duration in clock cycles (at least 1).
REQ-006 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-007 SHALL have port rst_n, input, 1; one clock, reset asynchronous and active-low.
REQ-008 SHALL have port digit_in, input, DIGIT_W, entered digit.
REQ-009 SHALL have port digit_vld, input, 1, digit_in is accepted on this clock edge.
REQ-010 SHALL have port clear, input, 1, acknowledge CLOSED and return to entry.
REQ-011 SHALL have port relock, input, 1, leave OPEN and return to entry.
REQ-012 SHALL have port prog, input, 1, enter code-programming mode from OPEN.
REQ-013 SHALL have port status, output, 3: 0=ENTRY, 1=OPEN, 2=CLOSED, 3=LOCKOUT, 4=PROGRAM.
REQ-014 SHALL have port digit_idx, output, 4, count of digits accepted in the current attempt or program pass.
REQ-015 SHALL have port fail_cnt, output, 4, consecutive failed attempts.
REQ-016 SHALL have port bad_digit, output, 1, combinational: digit_vld high and digit_in > 9.

Function
REQ-017 SHALL be registered: status, digit_idx, fail_cnt, the mismatch flag, the lockout counter and the stored code; bad_digit alone is combinational.
REQ-018 In ENTRY, each digit_vld SHALL compare digit_in with stored digit[digit_idx]; a mismatch or invalid digit sets the sticky mismatch flag; digit_idx increments.
REQ-019 On the edge accepting digit N_DIGITS-1 in ENTRY, SHALL go to OPEN if no mismatch (including this digit), otherwise go to CLOSED and increment fail_cnt; digit_idx and the mismatch flag clear on the same edge.
REQ-020 If that failure makes fail_cnt equal MAX_FAILS, SHALL go to LOCKOUT instead of CLOSED and load the lockout counter with LOCK_CYCLES-1.
REQ-021 Entering OPEN SHALL clear fail_cnt to 0.
REQ-022 CLOSED SHALL self-loop, ignoring digit_vld, until clear is high; then go to ENTRY on the next edge.
REQ-023 LOCKOUT SHALL ignore all inputs and decrement the counter each cycle; when it is 0, go to ENTRY and clear fail_cnt (exactly LOCK_CYCLES cycles in LOCKOUT).
REQ-024 OPEN SHALL self-loop, ignoring digit_vld.
- relock high: go to ENTRY.
- prog high (relock low): go to PROGRAM.
- relock and prog both high: relock wins.
REQ-025 PROGRAM SHALL shift each valid digit into a shadow register; after N_DIGITS digits, commit the shadow to the stored code on that edge and go to ENTRY.
REQ-026 An invalid digit in PROGRAM SHALL abort: shadow discarded, stored code unchanged, digit_idx cleared, return to OPEN.
REQ-027 A new code SHALL take effect from the first digit of the next ENTRY attempt.
REQ-028 Inputs other than those named for the current state SHALL be ignored.
REQ-029 fail_cnt SHALL never exceed MAX_FAILS.

Reset
REQ-030 With rst_n low, asynchronously and independent of clk, SHALL set: status=ENTRY, digit_idx=0, fail_cnt=0, mismatch flag=0, lockout counter=0, stored code=CODE_RST, shadow=0.
REQ-031 Reset asserted mid-attempt, in LOCKOUT or in PROGRAM SHALL abandon the operation; a partial program pass is never committed.
REQ-032 After rst_n deasserts, the first edge SHALL already accept digit_vld.

Verification
REQ-033 Default params, digits 7,2,2,2,9,7 -> status=OPEN after the 6th edge, fail_cnt=0; relock -> ENTRY.
REQ-034 Digits 7,0,2,2,9,7 -> CLOSED, fail_cnt=1; clear -> ENTRY; digits 10,1,2,3,4,5 -> bad_digit high on the first digit, CLOSED, fail_cnt=2.
REQ-035 Three consecutive wrong attempts -> LOCKOUT for exactly 16 cycles with digit_vld toggling and no effect -> ENTRY, fail_cnt=0.
REQ-036 OPEN, prog, digits 1,2,3,4,5,6 -> ENTRY; 7,2,2,2,9,7 -> CLOSED; clear; 1,2,3,4,5,6 -> OPEN.
REQ-037 OPEN, prog, digits 1,2,11 -> OPEN with code unchanged; rst_n pulsed mid-attempt and mid-program -> immediate ENTRY and code 722297.
